// File: rtl/risc_pkg.sv
// ============================================================================
// risc_pkg : shared state encodings and defaults for the RISC stage sequencer
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package risc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/seq_wait_timer.sv
// ============================================================================
// seq_wait_timer : counts memory wait cycles, flags the cycle that hits the limit
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] C_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (inc) begin
      count_d = count_q + 8'd1;
    end
  end

  // Fires on the wait cycle that would make the count reach MEM_TIMEOUT.
  assign expired = inc && (count_q == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/risc_stage_sequencer.sv
// ============================================================================
// risc_stage_sequencer : multi-cycle stage controller, PC and retire counter
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module risc_stage_sequencer
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] PC_STEP     = DEFAULT_PC_STEP,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_ready,
  input  logic                is_halt,
  input  logic                isld,
  input  logic                isst,
  input  logic                isbranchtaken,
  input  logic [31:0]         branchpc,
  output logic [31:0]         pc,
  output logic                if_en,
  output logic                of_en,
  output logic                ex_en,
  output logic                ma_en,
  output logic                wb_en,
  output logic                mem_req,
  output logic                mem_rw,
  output logic [STATE_W-1:0]  state,
  output logic                halted,
  output logic                timeout_err,
  output logic [31:0]         instr_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] count_q, count_d;
  logic        is_store_q, is_store_d;
  logic        halted_q, halted_d;
  logic        timeout_err_q, timeout_err_d;

  logic w_waiting;
  logic w_expired;

  assign w_waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_waiting),
    .inc     (w_waiting && !mem_ready),
    .expired (w_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    next_pc_d     = next_pc_q;
    count_d       = count_q;
    is_store_d    = is_store_q;
    halted_d      = halted_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH, ST_MEM: begin
        if (mem_ready) begin
          state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_WB;
        end else if (w_expired) begin
          state_d       = ST_HALT;
          halted_d      = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (is_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        next_pc_d  = isbranchtaken ? branchpc : (pc_q + PC_STEP);
        // Store direction is captured here so mem_rw has no input path in MEM.
        is_store_d = isst;
        state_d    = (isld || isst) ? ST_MEM : ST_WB;
      end
      ST_WB: begin
        pc_d    = next_pc_q;
        count_d = count_q + 32'd1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if_en   = 1'b0;
    of_en   = 1'b0;
    ex_en   = 1'b0;
    ma_en   = 1'b0;
    wb_en   = 1'b0;
    mem_req = 1'b0;
    mem_rw  = 1'b0;
    case (state_q)
      ST_FETCH:  begin if_en = 1'b1; mem_req = 1'b1; end
      ST_DECODE: of_en = 1'b1;
      ST_EXEC:   ex_en = 1'b1;
      ST_MEM:    begin ma_en = 1'b1; mem_req = 1'b1; mem_rw = is_store_q; end
      ST_WB:     wb_en = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      next_pc_q     <= RESET_PC;
      count_q       <= 32'd0;
      is_store_q    <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      next_pc_q     <= next_pc_d;
      count_q       <= count_d;
      is_store_q    <= is_store_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pc          = pc_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire
